prbs15_checker: RTL

- Receive-side counterpart to the PRBS-15 byte generator: consumes an 8-bit PRBS-15 byte stream, self-synchronises an internal LFSR to it, then checks every byte and accumulates bit errors.
- Sits at the far end of the link, where it produces lock status and error statistics for link-quality measurement, alongside the pattern detector.

---
 rtl/prbs15_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/prbs15_checker.sv
// PRBS-15 (x^15+x^14+1) byte-stream checker: self-synchronising lock, per-byte error count, saturating error total.
// Optional macro PRBS15_CHK_INVERT_EN adds an inv input that inverts data_in before seeding and checking.
module prbs15_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        clr_cnt,
`ifdef PRBS15_CHK_INVERT_EN
  input  logic        inv,
`endif
  output logic        locked,
  output logic        byte_err,
  output logic [3:0]  err_bits,
  output logic [31:0] err_cnt
);

  localparam int unsigned LFSR_W = 15;
  localparam int unsigned RUN_W  = 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {SEED0, SEED1, ACQUIRE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [6:0]         seed_q, seed_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q, locked_d;
  logic               byte_err_q, byte_err_d;
  logic [3:0]         err_bits_q, err_bits_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [7:0]         din_c;
  logic [7:0]         exp_c;
  logic [7:0]         diff_c;
  logic [3:0]         nerr_c;
  logic [LFSR_W-1:0]  lfsr_adv_c;
  logic [RUN_W:0]     run_inc_c;
  logic [CNT_W:0]     sum_c;
  logic [CNT_W-1:0]   sat_c;

`ifdef PRBS15_CHK_INVERT_EN
  assign din_c = data_in ^ {8{inv}};
`else
  assign din_c = data_in;
`endif

  // Expected byte and free-run successor: 8 LFSR steps, first step lands in bit 7.
  always_comb begin
    logic [LFSR_W-1:0] s;
    logic              b;
    s     = lfsr_q;
    exp_c = '0;
    for (int i = 0; i < 8; i++) begin
      b          = s[14] ^ s[13];
      exp_c[7-i] = b;
      s          = {s[13:0], b};
    end
    lfsr_adv_c = s;
  end

  assign diff_c = din_c ^ exp_c;

  always_comb begin
    nerr_c = '0;
    for (int i = 0; i < 8; i++) begin
      nerr_c = nerr_c + 4'(diff_c[i]);
    end
  end

  assign run_inc_c = (RUN_W+1)'(run_q) + (RUN_W+1)'(1);
  assign sum_c     = {1'b0, err_cnt_q} + (CNT_W+1)'(nerr_c);
  assign sat_c     = sum_c[CNT_W] ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_d     = seed_q;
    run_d      = run_q;
    byte_err_d = 1'b0;
    err_bits_d = err_bits_q;
    err_cnt_d  = clr_cnt ? '0 : err_cnt_q;

    if (data_valid) begin
      unique case (state_q)
        SEED0: begin
          seed_d  = din_c[6:0];
          state_d = SEED1;
        end
        SEED1: begin
          lfsr_d  = {seed_q, din_c};
          run_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          byte_err_d = (nerr_c != 4'd0);
          err_bits_d = nerr_c;
          lfsr_d     = {lfsr_q[6:0], din_c};
          if (nerr_c == 4'd0) begin
            if (run_inc_c >= (RUN_W+1)'(LOCK_CNT)) begin
              run_d   = '0;
              state_d = LOCKED;
            end else begin
              run_d = run_inc_c[RUN_W-1:0];
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          byte_err_d = (nerr_c != 4'd0);
          err_bits_d = nerr_c;
          lfsr_d     = lfsr_adv_c;
          if (!clr_cnt) begin
            err_cnt_d = sat_c;
          end
          if (nerr_c != 4'd0) begin
            if (run_inc_c >= (RUN_W+1)'(LOSS_CNT)) begin
              run_d   = '0;
              state_d = SEED0;
            end else begin
              run_d = run_inc_c[RUN_W-1:0];
            end
          end else begin
            run_d = '0;
          end
        end
        default: state_d = SEED0;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SEED0;
      lfsr_q     <= '0;
      seed_q     <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      byte_err_q <= 1'b0;
      err_bits_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      byte_err_q <= byte_err_d;
      err_bits_q <= err_bits_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign byte_err = byte_err_q;
  assign err_bits = err_bits_q;
  assign err_cnt  = err_cnt_q;

endmodule
